// File: rtl/config_reg_bank.sv
// config_reg_bank
//   Bank of NUM_REGS configuration registers at consecutive addresses starting
//   at BASE_ADDR. It takes read/write commands over a val/rdy handshake and
//   returns exactly one response per accepted command. The response buffer
//   holds a single entry. All register contents drive the cfg_out bus in
//   parallel, and cfg_update gives a one-cycle strobe per written register.
//
//   Optional feature (macro CONFIG_REG_LOCK_EN): bit 0 of register NUM_REGS-1
//   is a lock bit. While it is set, writes to every other register are
//   rejected with send_err=1.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous, active-low reset
//   recv_msg   : command {addr, wen, payload}
//   recv_val   : command valid
//   recv_rdy   : command ready (!send_val || send_rdy)
//   send_msg   : response {addr, wen, data}
//   send_err   : response error flag, qualified by send_val
//   send_val   : response valid
//   send_rdy   : response ready
//   cfg_out    : register i at bits [i*PAYLOAD_SIZE +: PAYLOAD_SIZE]
//   cfg_update : bit i pulses for one cycle after register i is written
module config_reg_bank #(
  parameter int unsigned ADDR_SIZE    = 4,
  parameter int unsigned PAYLOAD_SIZE = 8,
  parameter int unsigned NUM_REGS     = 4,
  parameter int unsigned BASE_ADDR    = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [ADDR_SIZE+PAYLOAD_SIZE:0]     recv_msg,
  input  logic                                recv_val,
  output logic                                recv_rdy,
  output logic [ADDR_SIZE+PAYLOAD_SIZE:0]     send_msg,
  output logic                                send_err,
  output logic                                send_val,
  input  logic                                send_rdy,
  output logic [NUM_REGS*PAYLOAD_SIZE-1:0]    cfg_out,
  output logic [NUM_REGS-1:0]                 cfg_update
);

  logic [PAYLOAD_SIZE-1:0] regs [NUM_REGS];

  logic [ADDR_SIZE-1:0]    cmd_addr;
  logic                    cmd_wen;
  logic [PAYLOAD_SIZE-1:0] cmd_payload;
  assign {cmd_addr, cmd_wen, cmd_payload} = recv_msg;

  // The offset is computed one bit wider than the address. An address below
  // BASE_ADDR wraps to a value >= 2^ADDR_SIZE, so it can never match a
  // register index. This handles both range bounds with one subtraction.
  logic [ADDR_SIZE:0] idx_full;
  assign idx_full = {1'b0, cmd_addr} - (ADDR_SIZE+1)'(BASE_ADDR);

  logic [NUM_REGS-1:0] sel;
  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (idx_full == (ADDR_SIZE+1)'(i)) sel[i] = 1'b1;
  end

  logic [PAYLOAD_SIZE-1:0] rd_data;
  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (sel[i]) rd_data = regs[i];
  end

  logic in_range;
  assign in_range = |sel;

  logic wr_allowed;
`ifdef CONFIG_REG_LOCK_EN
  // The lock register itself stays writable so the bank can be unlocked.
  assign wr_allowed = !regs[NUM_REGS-1][0] || sel[NUM_REGS-1];
`else
  assign wr_allowed = 1'b1;
`endif

  logic cmd_ok;
  assign cmd_ok = in_range && (!cmd_wen || wr_allowed);

  logic [PAYLOAD_SIZE-1:0] resp_data;
  always_comb begin
    resp_data = '0;
    if (cmd_ok) resp_data = cmd_wen ? cmd_payload : rd_data;
  end

  assign recv_rdy = !send_val || send_rdy;

  logic accept;
  assign accept = recv_val && recv_rdy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      send_val   <= 1'b0;
      send_err   <= 1'b0;
      send_msg   <= '0;
      cfg_update <= '0;
    end else begin
      cfg_update <= '0;
      if (accept) begin
        send_val <= 1'b1;
        send_err <= !cmd_ok;
        send_msg <= {cmd_addr, cmd_wen, resp_data};
        if (cmd_ok && cmd_wen) begin
          for (int unsigned i = 0; i < NUM_REGS; i++)
            if (sel[i]) regs[i] <= cmd_payload;
          cfg_update <= sel;
        end
      end else if (send_rdy) begin
        send_val <= 1'b0;
      end
    end
  end

  always_comb begin
    cfg_out = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      cfg_out[i*PAYLOAD_SIZE +: PAYLOAD_SIZE] = regs[i];
  end

endmodule
